// File: rtl/conv_filter_pipe.sv
// conv_filter_pipe: signed 3x3 (or programmable) window convolution with
// clamp to the unsigned pixel range. Two-stage elastic pipeline:
//   S1 holds the full-precision accumulator and the shift chosen at accept,
//   S2 holds the clamped pixel plus its saturation flag.
// Built-in kernels (window index 0 top-left, row-major, centre = 4):
//   mode 0 Lap4  :  0 -1  0 / -1  4 -1 /  0 -1  0   shift 0
//   mode 1 Lap8  : -1 -1 -1 / -1  8 -1 / -1 -1 -1   shift 0
//   mode 2 Gauss :  1  2  1 /  2  4  2 /  1  2  1   shift 4
//   mode 3       : programmed coefficients and shift
module conv_filter_pipe #(
  parameter int P_DATA_BW  = 10,
  parameter int P_WIN_SIZE = 9,
  parameter int P_COEF_BW  = 6,
  parameter int P_SHIFT_BW = 4,
  parameter int P_CNT_BW   = 16
) (
  input  logic                              i_clk,
  input  logic                              i_rstn,
  input  logic [1:0]                        i_config,
  input  logic                              i_coef_we,
  input  logic [$clog2(P_WIN_SIZE)-1:0]     i_coef_addr,
  input  logic [P_COEF_BW-1:0]              i_coef_wdata,
  input  logic                              i_shift_we,
  input  logic [P_SHIFT_BW-1:0]             i_shift_wdata,
  input  logic                              i_dxi_in_valid,
  output logic                              o_dxi_in_ready,
  input  logic [P_DATA_BW*P_WIN_SIZE-1:0]   i_dxi_in_data,
  output logic [P_DATA_BW-1:0]              o_dxi_out_data,
  output logic                              o_dxi_out_sat,
  output logic                              o_dxi_out_valid,
  input  logic                              i_dxi_out_ready,
  input  logic                              i_sat_clr,
  output logic [P_CNT_BW-1:0]               o_sat_cnt
);

  localparam int ACC_BW = P_DATA_BW + P_COEF_BW + $clog2(P_WIN_SIZE) + 1;
  localparam int CENTRE = P_WIN_SIZE / 2;
  localparam logic signed [ACC_BW-1:0] C_PIX_MAX = ACC_BW'((1 << P_DATA_BW) - 1);

  // The built-in kernels are 3x3 only; any other window size cannot use them.
  if (P_WIN_SIZE != 9) begin : g_win_chk
    $error("conv_filter_pipe: built-in kernels require P_WIN_SIZE == 9");
  end

  logic signed [P_COEF_BW-1:0]  r_coef [P_WIN_SIZE];
  logic [P_SHIFT_BW-1:0]        r_shift_prog;
  logic                         r_v1;
  logic signed [ACC_BW-1:0]     r_acc;
  logic [P_SHIFT_BW-1:0]        r_sh1;
  logic                         r_v2;
  logic [P_DATA_BW-1:0]         r_data;
  logic                         r_sat;
  logic [P_CNT_BW-1:0]          r_sat_cnt;

  logic                         w_adv1;
  logic                         w_adv2;
  logic                         w_accept;
  logic signed [ACC_BW-1:0]     w_acc;
  logic signed [ACC_BW-1:0]     w_pix;
  logic signed [ACC_BW-1:0]     w_c;
  logic [P_SHIFT_BW-1:0]        w_shift_sel;
  logic signed [ACC_BW-1:0]     w_sh;
  logic [P_DATA_BW-1:0]         w_pix_out;
  logic                         w_sat;

  function automatic logic signed [ACC_BW-1:0] f_builtin(input logic [1:0] mode, input int k);
    int v;
    v = 0;
    case (mode)
      2'd0:    v = (k == 4) ? 4 : (((k % 2) == 1) ? -1 : 0);
      2'd1:    v = (k == 4) ? 8 : -1;
      default: v = (k == 4) ? 4 : (((k % 2) == 1) ? 2 : 1);
    endcase
    return ACC_BW'(v);
  endfunction

  assign w_adv2         = !r_v2 || i_dxi_out_ready;
  assign w_adv1         = !r_v1 || w_adv2;
  assign w_accept       = i_dxi_in_valid && w_adv1;
  assign o_dxi_in_ready = w_adv1;

  // Programmable coefficient file; reset to the identity kernel
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int k = 0; k < P_WIN_SIZE; k++) r_coef[k] <= '0;
      r_coef[CENTRE] <= P_COEF_BW'(1);
    end else if (i_coef_we && (int'(i_coef_addr) < P_WIN_SIZE)) begin
      r_coef[i_coef_addr] <= i_coef_wdata;
    end
  end

  // Programmable shift register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)         r_shift_prog <= '0;
    else if (i_shift_we) r_shift_prog <= i_shift_wdata;
  end

  // Full-precision multiply-accumulate of the incoming window
  always_comb begin
    w_acc = '0;
    w_pix = '0;
    w_c   = '0;
    for (int k = 0; k < P_WIN_SIZE; k++) begin
      w_pix = ACC_BW'({1'b0, i_dxi_in_data[k*P_DATA_BW +: P_DATA_BW]});
      w_c   = (i_config == 2'd3) ? ACC_BW'(r_coef[k]) : f_builtin(i_config, k);
      w_acc = w_acc + w_c * w_pix;
    end
  end

  // Shift is fixed by the mode, except for the programmable kernel
  always_comb begin
    w_shift_sel = '0;
    if (i_config == 2'd3)      w_shift_sel = r_shift_prog;
    else if (i_config == 2'd2) w_shift_sel = P_SHIFT_BW'(4);
  end

  // S1: capture accumulator and shift on accept
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_v1  <= 1'b0;
      r_acc <= '0;
      r_sh1 <= '0;
    end else if (w_adv1) begin
      r_v1 <= i_dxi_in_valid;
      if (w_accept) begin
        r_acc <= w_acc;
        r_sh1 <= w_shift_sel;
      end
    end
  end

  // Floor shift and clamp into the unsigned pixel range
  always_comb begin
    w_sh      = r_acc >>> r_sh1;
    w_pix_out = w_sh[P_DATA_BW-1:0];
    w_sat     = 1'b0;
    if (w_sh[ACC_BW-1]) begin
      w_pix_out = '0;
      w_sat     = 1'b1;
    end else if (w_sh > C_PIX_MAX) begin
      w_pix_out = '1;
      w_sat     = 1'b1;
    end
  end

  // S2: output register, held while the consumer stalls
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_v2   <= 1'b0;
      r_data <= '0;
      r_sat  <= 1'b0;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_data <= w_pix_out;
        r_sat  <= w_sat;
      end
    end
  end

  // Saturating count of clamped beats entering S2; clear has priority
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)                                           r_sat_cnt <= '0;
    else if (i_sat_clr)                                    r_sat_cnt <= '0;
    else if (w_adv2 && r_v1 && w_sat && (r_sat_cnt != '1)) r_sat_cnt <= r_sat_cnt + 1'b1;
  end

  assign o_dxi_out_data  = r_data;
  assign o_dxi_out_sat   = r_sat;
  assign o_dxi_out_valid = r_v2;
  assign o_sat_cnt       = r_sat_cnt;

endmodule
